spi_shift_reg: RTL and testbench

//  Serial data engine paired with spi_clk_gen. Loads a parallel word, drives MOSI and samples

---
 rtl/spi_shift_reg.sv | 123 ++++++++++++
 tb/tb_spi_shift_reg.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - SPI serial data engine driven by spi_clk_gen edge strobes
// Optional feature macro: SPI_SHIFT_LSB_FIRST_EN (adds i_lsb, per-transfer LSB-first order)
module spi_shift_reg #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tx_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_tx_negedge,
    input  logic              i_rx_negedge,
    input  logic              i_pos_edge,
    input  logic              i_neg_edge,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_miso,
`ifdef SPI_SHIFT_LSB_FIRST_EN
    input  logic              i_lsb,
`endif
    output logic              o_mosi,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_busy,
    output logic              o_last_clk,
    output logic              o_done
);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    localparam logic [LEN_W:0] FULL_LEN = (LEN_W+1)'(DATA_W);
    localparam logic [LEN_W:0] ONE      = (LEN_W+1)'(1);

    state_t            state;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] rx_next;
    logic [LEN_W:0]    len_q;
    logic [LEN_W:0]    tx_cnt;
    logic [LEN_W:0]    rx_cnt;
    logic [LEN_W:0]    len_start;
    logic [LEN_W-1:0]  tx_idx;
    logic [LEN_W-1:0]  rx_idx;
    logic              tx_stb;
    logic              rx_stb;
    logic              lsb_q;

`ifdef SPI_SHIFT_LSB_FIRST_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            lsb_q <= 1'b0;
        else if (state == ST_IDLE && i_tx_start)
            lsb_q <= i_lsb;
    end
`else
    assign lsb_q = 1'b0;
`endif

    assign len_start  = (i_len == '0) ? FULL_LEN : {1'b0, i_len};
    assign tx_stb     = i_tx_negedge ? i_neg_edge : i_pos_edge;
    assign rx_stb     = i_rx_negedge ? i_neg_edge : i_pos_edge;
    assign o_last_clk = o_busy && (tx_cnt <= ONE);

    // tx_cnt counts bits still to send, so the index walks down (MSB-first) or up (LSB-first)
    assign tx_idx = lsb_q ? LEN_W'(len_q - tx_cnt) : LEN_W'(tx_cnt - ONE);
    assign rx_idx = LEN_W'(rx_cnt);

    always_comb begin
        rx_next = {rx_sr[DATA_W-2:0], i_miso};
        if (lsb_q) begin
            rx_next         = rx_sr;
            rx_next[rx_idx] = i_miso;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            tx_sr     <= '0;
            rx_sr     <= '0;
            len_q     <= '0;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
            o_mosi    <= 1'b0;
            o_rx_data <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_tx_start) begin
                        tx_sr  <= i_tx_data;
                        len_q  <= len_start;
                        tx_cnt <= len_start;
                        rx_cnt <= '0;
                        rx_sr  <= '0;
                        o_busy <= 1'b1;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tx_stb && tx_cnt != '0) begin
                        o_mosi <= tx_sr[tx_idx];
                        tx_cnt <= tx_cnt - ONE;
                    end
                    if (rx_stb && rx_cnt != len_q) begin
                        rx_sr  <= rx_next;
                        rx_cnt <= rx_cnt + ONE;
                        // Result is published on the same edge so o_done and o_rx_data align
                        if (rx_cnt + ONE == len_q) begin
                            o_rx_data <= rx_next;
                            o_done    <= 1'b1;
                            o_busy    <= 1'b0;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_reg.sv
// tb/tb_spi_shift_reg.sv - directed self-checking bench for spi_shift_reg
module tb_spi_shift_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_start;
    logic [4:0]  len;
    logic        tx_negedge;
    logic        rx_negedge;
    logic        pos_edge;
    logic        neg_edge;
    logic [31:0] tx_data;
    logic        miso_val;
    logic        loop;
    logic        miso;
`ifdef SPI_SHIFT_LSB_FIRST_EN
    logic        lsb;
`endif
    logic        mosi;
    logic [31:0] rx_data;
    logic        busy;
    logic        last_clk;
    logic        done;

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    logic [31:0] done_data = '0;
    logic [31:0] mosi_rec = '0;
    int          mosi_n = 0;
    int          p;

    always #5 clk = ~clk;
    assign miso = loop ? mosi : miso_val;

    spi_shift_reg #(.DATA_W(32), .LEN_W(5)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_tx_start   (tx_start),
        .i_len        (len),
        .i_tx_negedge (tx_negedge),
        .i_rx_negedge (rx_negedge),
        .i_pos_edge   (pos_edge),
        .i_neg_edge   (neg_edge),
        .i_tx_data    (tx_data),
        .i_miso       (miso),
`ifdef SPI_SHIFT_LSB_FIRST_EN
        .i_lsb        (lsb),
`endif
        .o_mosi       (mosi),
        .o_rx_data    (rx_data),
        .o_busy       (busy),
        .o_last_clk   (last_clk),
        .o_done       (done)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (done) begin
            done_cnt++;
            done_data = rx_data;
        end
    endtask

    task automatic start_xfer(input logic [4:0] l, input logic [31:0] d, input logic tneg, input logic rneg);
        len = l; tx_data = d; tx_negedge = tneg; rx_negedge = rneg;
        done_cnt = 0; mosi_rec = '0; mosi_n = 0;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
    endtask

    task automatic pulse(input logic pe, input logic ne);
        pos_edge = pe; neg_edge = ne;
        tick();
        pos_edge = 1'b0; neg_edge = 1'b0;
        if ((tx_negedge && ne) || (!tx_negedge && pe)) begin
            mosi_rec = {mosi_rec[30:0], mosi};
            mosi_n++;
        end
    endtask

    // Stand-in for spi_clk_gen: one SCLK period per loop, optional mid-transfer restart attempt
    task automatic spi_run(input int div, input logic first_neg, input logic coinc,
                           input int max_p, input int restart_p, output int periods);
        periods = 0;
        while (busy && periods < max_p) begin
            if (periods == restart_p) begin
                tx_data = 32'h0; tx_start = 1'b1;
                tick();
                tx_start = 1'b0;
            end
            if (coinc) begin
                pulse(1'b1, 1'b1);
            end else begin
                repeat (div) tick();
                pulse(!first_neg, first_neg);
                repeat (div) tick();
                pulse(first_neg, !first_neg);
            end
            periods++;
        end
    endtask

    task automatic test_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        total++; if (mosi !== 1'b0) begin bad++; $display("FAIL rst_mosi: got %b expected 0", mosi); end
        total++; if (last_clk !== 1'b0) begin bad++; $display("FAIL rst_last_clk: got %b expected 0", last_clk); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b expected 0", done); end
        total++; if (rx_data !== 32'h0) begin bad++; $display("FAIL rst_rx_data: got %h expected 0", rx_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        loop = 1'b1;
        start_xfer(5'd8, 32'hA5, 1'b1, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_latency: got %b expected 1", busy); end
        total++; if (last_clk !== 1'b0) begin bad++; $display("FAIL basic_last_clk_early: got %b expected 0", last_clk); end
        spi_run(4, 1'b1, 1'b0, 40, -1, p);
        repeat (2) tick();
        total++; if (p !== 8) begin bad++; $display("FAIL basic_sclk_periods: got %0d expected 8", p); end
        total++; if (mosi_rec[7:0] !== 8'hA5 || mosi_n !== 8) begin bad++; $display("FAIL basic_mosi: got %h/%0d expected a5/8", mosi_rec[7:0], mosi_n); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
        total++; if (done_data !== 32'h000000A5) begin bad++; $display("FAIL basic_rx_at_done: got %h expected 000000a5", done_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_full_len();
        loop = 1'b0; miso_val = 1'b1;
        start_xfer(5'd0, 32'hDEADBEEF, 1'b1, 1'b0);
        total++; if (last_clk !== 1'b0) begin bad++; $display("FAIL full_last_clk_early: got %b expected 0", last_clk); end
        spi_run(1, 1'b1, 1'b0, 40, -1, p);
        repeat (2) tick();
        total++; if (p !== 32) begin bad++; $display("FAIL full_sclk_periods: got %0d expected 32", p); end
        total++; if (mosi_rec !== 32'hDEADBEEF || mosi_n !== 32) begin bad++; $display("FAIL full_mosi: got %h/%0d expected deadbeef/32", mosi_rec, mosi_n); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL full_done_pulses: got %0d expected 1", done_cnt); end
        total++; if (rx_data !== 32'hFFFFFFFF) begin bad++; $display("FAIL full_rx_data: got %h expected ffffffff", rx_data); end
    endtask

    task automatic test_div0();
        loop = 1'b0; miso_val = 1'b0;
        start_xfer(5'd1, 32'h1, 1'b1, 1'b0);
        total++; if (busy !== 1'b1 || last_clk !== 1'b1) begin bad++; $display("FAIL div0_last_clk_first: got busy=%b last=%b expected 1/1", busy, last_clk); end
        spi_run(0, 1'b0, 1'b1, 40, -1, p);
        repeat (2) tick();
        total++; if (p !== 1) begin bad++; $display("FAIL div0_periods: got %0d expected 1", p); end
        total++; if (mosi_rec[0] !== 1'b1 || mosi_n !== 1) begin bad++; $display("FAIL div0_mosi: got %b/%0d expected 1/1", mosi_rec[0], mosi_n); end
        total++; if (done_cnt !== 1 || rx_data !== 32'h0) begin bad++; $display("FAIL div0_rx: got %h done=%0d expected 0 done=1", rx_data, done_cnt); end
    endtask

    task automatic test_restart_ignored();
        loop = 1'b1;
        start_xfer(5'd8, 32'hA5, 1'b1, 1'b0);
        spi_run(2, 1'b1, 1'b0, 40, 3, p);
        repeat (4) tick();
        total++; if (mosi_rec[7:0] !== 8'hA5 || mosi_n !== 8) begin bad++; $display("FAIL restart_mosi: got %h/%0d expected a5/8", mosi_rec[7:0], mosi_n); end
        total++; if (rx_data !== 32'hA5) begin bad++; $display("FAIL restart_rx: got %h expected 000000a5", rx_data); end
        total++; if (done_cnt !== 1 || busy !== 1'b0) begin bad++; $display("FAIL restart_single_done: got done=%0d busy=%b expected 1/0", done_cnt, busy); end
    endtask

    task automatic test_pos_tx();
        loop = 1'b1;
        start_xfer(5'd5, 32'hFFFFFFF6, 1'b0, 1'b1);
        spi_run(1, 1'b0, 1'b0, 40, -1, p);
        repeat (2) tick();
        total++; if (mosi_rec[4:0] !== 5'b10110 || mosi_n !== 5) begin bad++; $display("FAIL postx_mosi: got %b/%0d expected 10110/5", mosi_rec[4:0], mosi_n); end
        total++; if (rx_data !== 32'h16 || done_cnt !== 1) begin bad++; $display("FAIL postx_rx: got %h done=%0d expected 00000016 done=1", rx_data, done_cnt); end
    endtask

    task automatic test_abort();
        loop = 1'b0; miso_val = 1'b1;
        start_xfer(5'd8, 32'hFF, 1'b1, 1'b0);
        spi_run(1, 1'b1, 1'b0, 3, -1, p);
        total++; if (busy !== 1'b1 || mosi !== 1'b1) begin bad++; $display("FAIL abort_pre: got busy=%b mosi=%b expected 1/1", busy, mosi); end
        #2 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || mosi !== 1'b0 || last_clk !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL abort_outputs: got busy=%b mosi=%b last=%b done=%b expected 0000", busy, mosi, last_clk, done); end
        total++; if (rx_data !== 32'h0) begin bad++; $display("FAIL abort_rx_data: got %h expected 0", rx_data); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
        loop = 1'b1;
        start_xfer(5'd4, 32'h9, 1'b1, 1'b0);
        spi_run(1, 1'b1, 1'b0, 40, -1, p);
        repeat (2) tick();
        total++; if (rx_data !== 32'h9 || done_cnt !== 1) begin bad++; $display("FAIL abort_restart: got %h done=%0d expected 00000009 done=1", rx_data, done_cnt); end
    endtask

    task automatic test_msb_short();
        loop = 1'b1;
        start_xfer(5'd4, 32'h1, 1'b1, 1'b0);
        spi_run(1, 1'b1, 1'b0, 40, -1, p);
        repeat (2) tick();
        total++; if (mosi_rec[3:0] !== 4'b0001 || rx_data !== 32'h1) begin bad++; $display("FAIL msb_short: got mosi=%b rx=%h expected 0001/00000001", mosi_rec[3:0], rx_data); end
    endtask

`ifdef SPI_SHIFT_LSB_FIRST_EN
    task automatic test_lsb_first();
        loop = 1'b1; lsb = 1'b1;
        start_xfer(5'd4, 32'h1, 1'b1, 1'b0);
        lsb = 1'b0;
        spi_run(1, 1'b1, 1'b0, 40, -1, p);
        repeat (2) tick();
        total++; if (mosi_rec[3:0] !== 4'b1000 || mosi_n !== 4) begin bad++; $display("FAIL lsb_mosi: got %b/%0d expected 1000/4", mosi_rec[3:0], mosi_n); end
        total++; if (rx_data !== 32'h1 || done_cnt !== 1) begin bad++; $display("FAIL lsb_rx: got %h done=%0d expected 00000001 done=1", rx_data, done_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b1; tx_start = 1'b0; len = '0; tx_negedge = 1'b0; rx_negedge = 1'b0;
        pos_edge = 1'b0; neg_edge = 1'b0; tx_data = '0; miso_val = 1'b0; loop = 1'b0;
`ifdef SPI_SHIFT_LSB_FIRST_EN
        lsb = 1'b0;
`endif
        repeat (2) tick();
        test_reset();
        test_basic();
        test_full_len();
        test_div0();
        test_restart_ignored();
        test_pos_tx();
        test_abort();
        test_msb_short();
`ifdef SPI_SHIFT_LSB_FIRST_EN
        test_lsb_first();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
